global_history_unit: RTL

- Speculative global-history and path-history store for the perceptron predictor.
- Sits between the fetch-stage prediction logic and the perceptron/bias table index and dot-product logic.
- Pushes predicted outcomes speculatively and hands out a checkpoint per prediction.
- On mispredict, restores from that checkpoint in one cycle. Presents the XOR-folded history and the path history to the perceptron datapath.

---
 rtl/global_history_unit_pkg.sv | 26 ++
 rtl/global_history_unit_ring_buffer.sv | 33 +++
 rtl/global_history_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/global_history_unit_pkg.sv
// global_history_unit_pkg: sizing, checkpoint type and pointer wrap helpers for the history unit
package global_history_unit_pkg;
    localparam int PATH_ENTRIES    = 32;
    localparam int PATH_HASH_WIDTH = 8;
    localparam int GHR_WIDTH       = 128;
    localparam int FOLD_WIDTH      = 64;
    localparam int MAX_INFLIGHT    = 64;
    localparam int GBUF            = GHR_WIDTH + MAX_INFLIGHT;
    localparam int PBUF            = PATH_ENTRIES + MAX_INFLIGHT;
    localparam int GPTR_W          = $clog2(GBUF);
    localparam int PPTR_W          = $clog2(PBUF);
    localparam int CNT_W           = $clog2(MAX_INFLIGHT + 1);

    typedef struct packed {
        logic [GPTR_W-1:0] gptr;
        logic [PPTR_W-1:0] pptr;
    } ckpt_t;

    function automatic logic [GPTR_W-1:0] ginc(input logic [GPTR_W-1:0] p);
        return (p == GPTR_W'(GBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PPTR_W-1:0] pinc(input logic [PPTR_W-1:0] p);
        return (p == PPTR_W'(PBUF - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/global_history_unit_ring_buffer.sv
// ghu_ring_buffer: circular store written at a pointer, read out newest-first behind the head
module ghu_ring_buffer #(
    parameter int DEPTH = 192,
    parameter int WIDTH = 1,
    parameter int OUT_N = 128,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [PTR_W-1:0]       waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [PTR_W-1:0]       head,
    output logic [OUT_N*WIDTH-1:0] lin
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage: cleared on reset, at most one entry written per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Entry j is the slot j+1 behind the head, wrapping through the top of the buffer
    always_comb begin
        lin = '0;
        for (int j = 0; j < OUT_N; j++)
            lin[j*WIDTH +: WIDTH] = mem_q[PTR_W'((int'(head) > j) ? int'(head) - 1 - j : int'(head) + DEPTH - 1 - j)];
    end
endmodule

// File: rtl/global_history_unit.sv
// global_history_unit: speculative global/path history with single-cycle checkpoint repair
// Path history storage is built only when GHU_PATH_HISTORY_EN is defined.
module global_history_unit
    import global_history_unit_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   spec_valid,
    output logic                                   spec_ready,
    input  logic                                   spec_taken,
    input  logic [PATH_HASH_WIDTH-1:0]             spec_pc_hash,
    output ckpt_t                                  spec_ckpt,
    input  logic                                   commit_valid,
    input  logic                                   repair_valid,
    input  ckpt_t                                  repair_ckpt,
    input  logic                                   repair_taken,
    input  logic [PATH_HASH_WIDTH-1:0]             repair_pc_hash,
    output logic [FOLD_WIDTH-1:0]                  fold_hist,
    output logic [PATH_ENTRIES*PATH_HASH_WIDTH-1:0] path_hist,
    output logic [CNT_W-1:0]                       inflight_cnt
);
    logic [GPTR_W-1:0]    gptr_q, gptr_d, gret_q, gret_d, g_waddr;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GPTR_W:0]      gdist;
    logic [GHR_WIDTH-1:0] ghr_lin;
    logic                 push, commit_fire, g_we, g_wdata;

    assign spec_ready   = cnt_q < CNT_W'(MAX_INFLIGHT);
    assign inflight_cnt = cnt_q;
    assign commit_fire  = commit_valid && cnt_q != '0;
    assign push         = spec_valid && spec_ready && !repair_valid;
    assign gret_d       = commit_fire ? ginc(gret_q) : gret_q;
    // Distance from the (already advanced) retire point to the repaired branch
    assign gdist        = (GPTR_W+1)'(repair_ckpt.gptr) + ((repair_ckpt.gptr >= gret_d) ? '0 : (GPTR_W+1)'(GBUF)) - (GPTR_W+1)'(gret_d);
    assign cnt_d        = repair_valid ? CNT_W'(gdist + 1'b1) : cnt_q + CNT_W'(push) - CNT_W'(commit_fire);
    assign gptr_d       = repair_valid ? ginc(repair_ckpt.gptr) : push ? ginc(gptr_q) : gptr_q;
    assign g_we         = push || repair_valid;
    assign g_waddr      = repair_valid ? repair_ckpt.gptr : gptr_q;
    assign g_wdata      = repair_valid ? repair_taken : spec_taken;

    // Head, retire pointer and in-flight count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gptr_q <= '0;
            gret_q <= '0;
            cnt_q  <= '0;
        end else begin
            gptr_q <= gptr_d;
            gret_q <= gret_d;
            cnt_q  <= cnt_d;
        end
    end

    ghu_ring_buffer #(.DEPTH(GBUF), .WIDTH(1), .OUT_N(GHR_WIDTH), .PTR_W(GPTR_W)) u_ghr (
        .clk(clk), .rst(rst), .we(g_we), .waddr(g_waddr), .wdata(g_wdata), .head(gptr_q), .lin(ghr_lin)
    );

    // Fold the linear history by XORing FOLD_WIDTH-bit slices together
    always_comb begin
        fold_hist = '0;
        for (int k = 0; k < GHR_WIDTH / FOLD_WIDTH; k++) fold_hist ^= ghr_lin[k*FOLD_WIDTH +: FOLD_WIDTH];
    end

    // A repair must name a branch still in flight
    always_ff @(posedge clk) begin
        if (!rst && repair_valid) assert (gdist < (GPTR_W+1)'(cnt_q));
    end

`ifdef GHU_PATH_HISTORY_EN
    logic [PPTR_W-1:0]          pptr_q, pptr_d, pret_q, pret_d, p_waddr;
    logic [PPTR_W:0]            pdist;
    logic [PATH_HASH_WIDTH-1:0] p_wdata;

    assign pret_d    = commit_fire ? pinc(pret_q) : pret_q;
    assign pptr_d    = repair_valid ? pinc(repair_ckpt.pptr) : push ? pinc(pptr_q) : pptr_q;
    assign p_waddr   = repair_valid ? repair_ckpt.pptr : pptr_q;
    assign p_wdata   = repair_valid ? repair_pc_hash : spec_pc_hash;
    assign pdist     = (PPTR_W+1)'(repair_ckpt.pptr) + ((repair_ckpt.pptr >= pret_d) ? '0 : (PPTR_W+1)'(PBUF)) - (PPTR_W+1)'(pret_d);
    assign spec_ckpt = '{gptr: gptr_q, pptr: pptr_q};

    // Path head and retire pointer move in lockstep with the GHR pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pptr_q <= '0;
            pret_q <= '0;
        end else begin
            pptr_q <= pptr_d;
            pret_q <= pret_d;
        end
    end

    // Both halves of a checkpoint must describe the same branch
    always_ff @(posedge clk) begin
        if (!rst && repair_valid) assert (int'(pdist) == int'(gdist));
    end

    ghu_ring_buffer #(.DEPTH(PBUF), .WIDTH(PATH_HASH_WIDTH), .OUT_N(PATH_ENTRIES), .PTR_W(PPTR_W)) u_path (
        .clk(clk), .rst(rst), .we(g_we), .waddr(p_waddr), .wdata(p_wdata), .head(pptr_q), .lin(path_hist)
    );
`else
    logic unused_path;
    assign unused_path = ^{spec_pc_hash, repair_pc_hash, repair_ckpt.pptr};
    assign path_hist   = '0;
    assign spec_ckpt   = '{gptr: gptr_q, pptr: '0};
`endif
endmodule
